// File: rtl/uart_bridge_pkg.sv
// Shared constants and types for the UART command bridge.
package uart_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  // Command opcodes received from the host.
  localparam logic [BYTE_W-1:0] OP_WR = 8'h57;
  localparam logic [BYTE_W-1:0] OP_RD = 8'h52;

  // Status bytes returned to the host.
  localparam logic [BYTE_W-1:0] RSP_OK  = 8'h4B;
  localparam logic [BYTE_W-1:0] RSP_ERR = 8'h45;
  localparam logic [BYTE_W-1:0] RSP_TMO = 8'h54;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_AW_W,
    ST_B_WAIT,
    ST_AR,
    ST_R_WAIT,
    ST_RESP
  } state_e;

  // Frame words arrive MSB first: shift the new byte in at the bottom.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] word,
                                                 input logic [BYTE_W-1:0] b);
    return {word[DATA_W-BYTE_W-1:0], b};
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bus bundle with wlast/rlast sidebands.
// Ports: aclk, aresetn. Modports: master (initiator), slave (target).
interface AXI_LITE (
  input logic aclk,
  input logic aresetn
);

  logic [uart_bridge_pkg::ADDR_W-1:0] awaddr;
  logic                               awvalid;
  logic                               awready;
  logic [uart_bridge_pkg::DATA_W-1:0] wdata;
  logic                               wvalid;
  logic                               wlast;
  logic                               wready;
  logic [1:0]                         bresp;
  logic                               bvalid;
  logic                               bready;
  logic [uart_bridge_pkg::ADDR_W-1:0] araddr;
  logic                               arvalid;
  logic                               arready;
  logic [uart_bridge_pkg::DATA_W-1:0] rdata;
  logic                               rvalid;
  logic                               rlast;
  logic                               rready;

  modport master (
    input  aclk, aresetn,
    output awaddr, awvalid, input awready,
    output wdata, wvalid, wlast, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rvalid, rlast, output rready
  );

  modport slave (
    input  aclk, aresetn,
    input  awaddr, awvalid, output awready,
    input  wdata, wvalid, wlast, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rvalid, rlast, input rready
  );

endinterface

// File: rtl/axi_lite_uart_master.sv
// Byte-stream command decoder issuing single AXI-Lite reads/writes and
// returning status/read data as a byte stream.
// Ports: aclk/aresetn (bus clock, async active-low reset), axi (AXI-Lite
// initiator), rx_* (command bytes in), tx_* (response bytes out),
// busy (high outside IDLE).
module axi_lite_uart_master
  import uart_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              aclk,
  input  logic              aresetn,
  AXI_LITE.master           axi,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic                is_wr_q, is_wr_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
  logic                bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                tx_valid_q, tx_valid_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic [DATA_W-1:0]   rsp_buf_q, rsp_buf_d;
  logic [2:0]          rsp_left_q, rsp_left_d;
  logic                rx_ready_q, rx_ready_d, busy_q, busy_d;
  logic                rx_fire_c, tmo_hit_c, abort_c;

  assign rx_fire_c = rx_valid && rx_ready_q;
  assign tmo_hit_c = (tmo_cnt_q == TMO_LAST);

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tmo_cnt_d  = tmo_cnt_q + TMO_W'(1);
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    wlast_d    = wlast_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    araddr_d   = araddr_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    rsp_buf_d  = rsp_buf_q;
    rsp_left_d = rsp_left_q;
    abort_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_fire_c) begin
          byte_cnt_d = 2'd0;
          if (rx_data == OP_WR) begin
            is_wr_d = 1'b1;
            state_d = ST_GET_ADDR;
          end else if (rx_data == OP_RD) begin
            is_wr_d = 1'b0;
            state_d = ST_GET_ADDR;
          end else begin
            tx_valid_d = 1'b1;
            tx_data_d  = RSP_ERR;
            rsp_left_d = 3'd0;
            state_d    = ST_RESP;
          end
        end
      end
      ST_GET_ADDR: begin
        if (rx_fire_c) begin
          addr_d     = shift_in(addr_q, rx_data);
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            tmo_cnt_d = '0;
            if (is_wr_q) begin
              state_d = ST_GET_DATA;
            end else begin
              arvalid_d = 1'b1;
              araddr_d  = shift_in(addr_q, rx_data);
              state_d   = ST_AR;
            end
          end
        end
      end
      ST_GET_DATA: begin
        if (rx_fire_c) begin
          data_d     = shift_in(data_q, rx_data);
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            tmo_cnt_d = '0;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wlast_d   = 1'b1;
            awaddr_d  = addr_q;
            wdata_d   = shift_in(data_q, rx_data);
            state_d   = ST_AW_W;
          end
        end
      end
      ST_AW_W: begin
        // Address and data handshakes complete independently.
        if (axi.awready) awvalid_d = 1'b0;
        if (axi.wready) begin
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
        end
        if (!awvalid_d && !wvalid_d) begin
          bready_d  = 1'b1;
          tmo_cnt_d = '0;
          state_d   = ST_B_WAIT;
        end else if (tmo_hit_c) begin
          abort_c = 1'b1;
        end
      end
      ST_B_WAIT: begin
        if (axi.bvalid) begin
          bready_d   = 1'b0;
          tx_valid_d = 1'b1;
          tx_data_d  = (axi.bresp == 2'b00) ? RSP_OK : RSP_ERR;
          rsp_left_d = 3'd0;
          state_d    = ST_RESP;
        end else if (tmo_hit_c) begin
          abort_c = 1'b1;
        end
      end
      ST_AR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          tmo_cnt_d = '0;
          state_d   = ST_R_WAIT;
        end else if (tmo_hit_c) begin
          abort_c = 1'b1;
        end
      end
      ST_R_WAIT: begin
        if (axi.rvalid) begin
          rready_d   = 1'b0;
          tx_valid_d = 1'b1;
          tx_data_d  = RSP_OK;
          rsp_buf_d  = axi.rdata;
          rsp_left_d = 3'd4;
          state_d    = ST_RESP;
        end else if (tmo_hit_c) begin
          abort_c = 1'b1;
        end
      end
      ST_RESP: begin
        if (tx_valid_q && tx_ready) begin
          if (rsp_left_q == 3'd0) begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            tx_data_d  = rsp_buf_q[DATA_W-1 -: BYTE_W];
            rsp_buf_d  = {rsp_buf_q[DATA_W-BYTE_W-1:0], BYTE_W'(0)};
            rsp_left_d = rsp_left_q - 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Silent slave: release the bus and report 'T'.
    if (abort_c) begin
      awvalid_d  = 1'b0;
      wvalid_d   = 1'b0;
      wlast_d    = 1'b0;
      bready_d   = 1'b0;
      arvalid_d  = 1'b0;
      rready_d   = 1'b0;
      tx_valid_d = 1'b1;
      tx_data_d  = RSP_TMO;
      rsp_left_d = 3'd0;
      state_d    = ST_RESP;
    end

    rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_GET_ADDR) || (state_d == ST_GET_DATA);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      is_wr_q    <= 1'b0;
      byte_cnt_q <= 2'd0;
      addr_q     <= '0;
      data_q     <= '0;
      tmo_cnt_q  <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      araddr_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      rsp_buf_q  <= '0;
      rsp_left_q <= 3'd0;
      rx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tmo_cnt_q  <= tmo_cnt_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      wlast_q    <= wlast_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      araddr_q   <= araddr_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      rsp_buf_q  <= rsp_buf_d;
      rsp_left_q <= rsp_left_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign axi.awaddr  = awaddr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.wlast   = wlast_q;
  assign axi.bready  = bready_q;
  assign axi.araddr  = araddr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign rx_ready    = rx_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;

endmodule
